// File: rtl/bcd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, per-digit slot with
// anti-ghost blanking, leading-zero suppression and shadow reload only at frame wrap.
module bcd_scan_ctrl #(
   parameter int unsigned N_DIGITS     = 6,
   parameter int unsigned PRESCALE     = 100000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                we_i,
   input  logic [31:0]         data_i,
   output logic [N_DIGITS-1:0] an_o,
   output logic [6:0]          seg_o,
   output logic [2:0]          digit_o,
   output logic                frame_o
);

   localparam int unsigned CNT_W   = $clog2(PRESCALE);
   localparam int unsigned SH_W    = 4 * N_DIGITS + 2;
   localparam int unsigned BLZ_BIT = 4 * N_DIGITS;
   localparam int unsigned EN_BIT  = BLZ_BIT + 1;

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [2:0]       DIG_LAST  = 3'(N_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_SHOW,
      ST_BLANK
   } state_t;

   state_t              state, state_n;
   logic [31:0]         live;
   logic [SH_W-1:0]     shadow, shadow_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [2:0]          digit_n;
   logic                frame_n;
   logic [N_DIGITS-1:0] an_n;
   logic [6:0]          seg_n;
   logic [N_DIGITS-1:0] blank_mask;
   logic                all_zero;
   logic [3:0]          nib;
   logic                blank_sel;

   // Bits above the shadowed field are kept in the register but never displayed.
   logic unused_live;
   assign unused_live = ^live[31:SH_W];

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h3F;
      endcase
   endfunction

   // Live register: CPU-visible, updates on every write.
   always_ff @(posedge clk_i) begin
      if (rst_i)     live <= '0;
      else if (we_i) live <= data_i;
   end

   // Scan state and registered display outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_OFF;
         shadow  <= '0;
         cnt     <= '0;
         digit_o <= '0;
         frame_o <= 1'b0;
         an_o    <= '1;
         seg_o   <= 7'h7F;
      end else begin
         state   <= state_n;
         shadow  <= shadow_n;
         cnt     <= cnt_n;
         digit_o <= digit_n;
         frame_o <= frame_n;
         an_o    <= an_n;
         seg_o   <= seg_n;
      end
   end

   // Next-state, then outputs decoded from the next-state values so they stay registered.
   always_comb begin
      state_n    = state;
      shadow_n   = shadow;
      cnt_n      = cnt + 1'b1;
      digit_n    = digit_o;
      frame_n    = 1'b0;
      an_n       = '1;
      seg_n      = 7'h7F;
      blank_mask = '0;
      all_zero   = 1'b1;
      nib        = 4'd0;
      blank_sel  = 1'b0;

      if (!live[EN_BIT]) begin
         state_n = ST_OFF;
         cnt_n   = '0;
         digit_n = '0;
      end else begin
         case (state)
            ST_OFF: begin
               state_n  = ST_SHOW;
               shadow_n = live[SH_W-1:0];
               cnt_n    = '0;
               digit_n  = '0;
               frame_n  = 1'b1;
            end
            ST_SHOW: begin
               if (cnt == SHOW_LAST) state_n = ST_BLANK;
            end
            ST_BLANK: begin
               if (cnt == SLOT_LAST) begin
                  state_n = ST_SHOW;
                  cnt_n   = '0;
                  if (digit_o == DIG_LAST) begin
                     digit_n  = '0;
                     shadow_n = live[SH_W-1:0];
                     frame_n  = 1'b1;
                  end else begin
                     digit_n = digit_o + 3'd1;
                  end
               end
            end
            default: begin
               state_n = ST_OFF;
               cnt_n   = '0;
               digit_n = '0;
            end
         endcase
      end

      // Digit i>0 is a leading zero when it and every higher nibble are zero.
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         all_zero      = all_zero & (shadow_n[4*i +: 4] == 4'd0);
         blank_mask[i] = shadow_n[BLZ_BIT] & all_zero & (i != 0);
      end

      for (int i = 0; i < N_DIGITS; i++) begin
         if (3'(i) == digit_n) begin
            nib       = shadow_n[4*i +: 4];
            blank_sel = blank_mask[i];
         end
      end

      if (state_n == ST_SHOW && !blank_sel) begin
         for (int i = 0; i < N_DIGITS; i++) an_n[i] = (3'(i) != digit_n);
         seg_n = seg_decode(nib);
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Randomized and directed bench for bcd_scan_ctrl against a frame-time reference model.
module tb_bcd_scan_ctrl;
   localparam int N = 6;
   localparam int P = 8;
   localparam int B = 2;
   localparam int FRAME = N * P;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        we_i;
   logic [31:0] data_i;
   logic [5:0]  an_o;
   logic [6:0]  seg_o;
   logic [2:0]  digit_o;
   logic        frame_o;

   int errors = 0;
   int checks = 0;

   // Reference model: display enabled flag plus position within the current frame.
   logic [31:0] m_live;
   logic [25:0] m_shadow;
   bit          m_on;
   int          m_t;
   bit          m_frame;

   bcd_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .data_i(data_i),
      .an_o(an_o), .seg_o(seg_o), .digit_o(digit_o), .frame_o(frame_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int seg_of(input int n);
      case (n)
         0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
         4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
         8: return 'h00;  9: return 'h10;
         default: return 'h3F;
      endcase
   endfunction

   task automatic model_step(input bit r, input bit w, input logic [31:0] d);
      logic [31:0] old_live;
      if (r) begin
         m_live = '0; m_shadow = '0; m_on = 0; m_t = 0; m_frame = 0;
      end else begin
         old_live = m_live;
         m_frame  = 0;
         if (!old_live[25]) begin
            m_on = 0; m_t = 0;
         end else if (!m_on) begin
            m_on = 1; m_t = 0; m_shadow = old_live[25:0]; m_frame = 1;
         end else begin
            m_t++;
            if (m_t == FRAME) begin
               m_t = 0; m_shadow = old_live[25:0]; m_frame = 1;
            end
         end
         if (w) m_live = d;
      end
   endtask

   task automatic compare();
      int d, ph, e_an, e_seg, e_dig;
      logic [23:0] rest;
      bit blanked;
      d       = m_t / P;
      ph      = m_t % P;
      rest    = m_shadow[23:0] >> (4 * d);
      blanked = (d > 0) && m_shadow[24] && (rest == 24'd0);
      e_dig   = m_on ? d : 0;
      e_an    = 'h3F;
      e_seg   = 'h7F;
      if (m_on && ph < P - B && !blanked) begin
         e_an  = 'h3F ^ (1 << d);
         e_seg = seg_of(int'(rest[3:0]));
      end
      check("an_o", int'(an_o), e_an);
      check("seg_o", int'(seg_o), e_seg);
      check("digit_o", int'(digit_o), e_dig);
      check("frame_o", int'(frame_o), int'(m_frame));
   endtask

   task automatic cyc(input bit r, input bit w, input logic [31:0] d);
      rst_i  = r;
      we_i   = w;
      data_i = d;
      @(posedge clk_i);
      model_step(r, w, d);
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 32'h0);
   endtask

   initial begin
      int nframes;
      logic [31:0] rd;
      m_live = '0; m_shadow = '0; m_on = 0; m_t = 0; m_frame = 0;
      rst_i = 1'b1; we_i = 1'b0; data_i = '0;

      for (int k = 0; k < 3; k++) cyc(1, 0, 32'h0);
      idle(20);

      // Basic display with leading-zero blanking, then without.
      cyc(0, 1, 32'h0300_0042);
      nframes = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         cyc(0, 0, 32'h0);
         if (frame_o) nframes++;
      end
      check("frame_count", nframes, 3);
      cyc(0, 1, 32'h0200_0042);
      idle(2 * FRAME);

      // Mid-frame write while digit1 is on screen.
      for (int k = 0; k < FRAME && !(m_on && m_t / P == 1); k++) cyc(0, 0, 32'h0);
      cyc(0, 1, 32'h0200_0099);
      idle(2 * FRAME);

      // Write on the same edge as the frame wrap.
      for (int k = 0; k < FRAME && m_t != FRAME - 1; k++) cyc(0, 0, 32'h0);
      cyc(0, 1, 32'h0200_0055);
      idle(2 * FRAME + 5);

      // Illegal nibbles show a dash; upper zeros blanked.
      cyc(0, 1, 32'h0300_00AF);
      idle(2 * FRAME);

      // Disable during SHOW, re-enable, then reset mid-SHOW.
      for (int k = 0; k < FRAME && !(m_on && m_t % P < P - B); k++) cyc(0, 0, 32'h0);
      cyc(0, 1, 32'h0000_0042);
      idle(6);
      cyc(0, 1, 32'h0300_0042);
      idle(FRAME + 10);
      for (int k = 0; k < FRAME && !(m_on && m_t % P < P - B); k++) cyc(0, 0, 32'h0);
      cyc(1, 0, 32'h0);
      idle(4);

      // Random traffic including occasional resets and disables.
      for (int k = 0; k < 1500; k++) begin
         rd = $urandom;
         rd[23:0] = rd[23:0] >> (4 * $urandom_range(0, 6));
         rd[25] = ($urandom_range(0, 9) != 0);
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
